// File: rtl/rqz_pkg.sv
// Shared requantizer-link definitions: sample geometry, receiver states and
// the code-to-sample alignment used on both ends of the link.
package rqz_pkg;

    localparam int unsigned DW   = 18;
    localparam int unsigned NQ_W = 5;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } rx_state_t;

    // Left-align an nq-bit code in a DW-bit sample; low bits are zero-filled.
    function automatic logic [DW-1:0] align(input logic [DW-1:0] code,
                                            input logic [NQ_W-1:0] nq);
        logic [NQ_W-1:0] sh;
        sh = NQ_W'(DW) - nq;
        return code << sh;
    endfunction

endpackage

// File: rtl/dequant_deserializer_if.sv
// Serial-link input and reconstructed-sample output of the dequantizing
// deserializer; master is the link/sink side, slave is the deserializer.
interface dequant_deserializer_if;
    import rqz_pkg::*;

    logic [NQ_W-1:0] Nquant;
    logic            sin;
    logic            sin_en;
    logic            sin_sync;
    logic [DW-1:0]   dataout;
    logic            dataout_en;
    logic            err;

    modport master (
        output Nquant, sin, sin_en, sin_sync,
        input  dataout, dataout_en, err
    );

    modport slave (
        input  Nquant, sin, sin_en, sin_sync,
        output dataout, dataout_en, err
    );

endinterface

// File: rtl/dequant_deserializer.sv
// Collects Nquant-bit MSB-first codes from the serial link and emits the
// left-aligned DW-bit two's-complement sample one cycle after the last bit.
module dequant_deserializer
    import rqz_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    dequant_deserializer_if.slave bus
);

    rx_state_t       state_q, state_d;
    logic [DW-1:0]   shift_q, shift_d;
    logic [NQ_W-1:0] cnt_q, cnt_d;
    logic [NQ_W-1:0] nq_q, nq_d;
    logic            done_q, done_d;
    logic            err_d;
    logic            nq_legal;

    assign nq_legal = (bus.Nquant != '0) && (bus.Nquant <= NQ_W'(DW));

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= IDLE;
            shift_q        <= '0;
            cnt_q          <= '0;
            nq_q           <= '0;
            done_q         <= 1'b0;
            bus.dataout    <= '0;
            bus.dataout_en <= 1'b0;
            bus.err        <= 1'b0;
        end else begin
            state_q        <= state_d;
            shift_q        <= shift_d;
            cnt_q          <= cnt_d;
            nq_q           <= nq_d;
            done_q         <= done_d;
            bus.err        <= err_d;
            bus.dataout_en <= done_q;
            // shift_q/nq_q still hold the finished code even if a new sync lands now
            if (done_q) begin
                bus.dataout <= align(shift_q, nq_q);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        nq_d    = nq_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        if (bus.sin_en) begin
            if (bus.sin_sync) begin
                // A sync always starts over: an early one aborts the partial code
                err_d   = (state_q == SHIFT) || !nq_legal;
                state_d = IDLE;
                if (nq_legal) begin
                    nq_d    = bus.Nquant;
                    shift_d = {{(DW-1){1'b0}}, bus.sin};
                    cnt_d   = NQ_W'(1);
                    if (bus.Nquant == NQ_W'(1)) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end else if (state_q == SHIFT) begin
                shift_d = {shift_q[DW-2:0], bus.sin};
                cnt_d   = cnt_q + 1'b1;
                if (cnt_d == nq_q) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_dequant_deserializer.sv
// Self-checking bench for dequant_deserializer: directed link scenarios plus a
// randomized code stream checked against a queue-based sample model.
module tb_dequant_deserializer;
    import rqz_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    dequant_deserializer_if bus();

    dequant_deserializer dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    logic [DW-1:0] obs_data;
    logic          obs_en;
    logic          obs_err;

    typedef struct packed {
        logic            en;
        logic            sync;
        logic            b;
        logic [NQ_W-1:0] nq;
    } stim_t;

    // One link cycle: sample outputs at the falling edge, then drive the next bit.
    task automatic tick(input logic en, input logic sync, input logic b,
                        input logic [NQ_W-1:0] nq);
        @(negedge clock);
        obs_data     = bus.dataout;
        obs_en       = bus.dataout_en;
        obs_err      = bus.err;
        bus.sin_en   = en;
        bus.sin_sync = sync;
        bus.sin      = b;
        bus.Nquant   = nq;
    endtask

    task automatic idle();
        tick(1'b0, 1'b0, 1'b0, '0);
    endtask

    function automatic logic [DW-1:0] ref_sample(input int unsigned code,
                                                 input int unsigned nq);
        int unsigned scaled;
        scaled = code * (32'd1 << (DW - nq));
        return scaled[DW-1:0];
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        idle();
        idle();
        vectors++;
        if (obs_en !== 1'b0 || obs_err !== 1'b0 || obs_data !== '0) begin
            miscompares++;
            $display("FAIL reset_state: en=%b err=%b data=%h, want 0/0/00000", obs_en, obs_err, obs_data);
        end
        reset = 1'b0;
        idle();
    endtask

    task automatic test_basic();
        logic [3:0] c;
        c = 4'b1011;
        for (int i = 3; i >= 0; i--) begin
            tick(1'b1, i == 3, c[i], 5'd4);
            vectors++;
            if (obs_en !== 1'b0 || obs_err !== 1'b0) begin
                miscompares++;
                $display("FAIL basic_quiet: en=%b err=%b, want 0/0", obs_en, obs_err);
            end
        end
        idle();
        vectors++;
        if (obs_en !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_early_strobe: en=%b, want 0", obs_en);
        end
        idle();
        vectors++;
        if (obs_en !== 1'b1 || obs_data !== 18'h2C000) begin
            miscompares++;
            $display("FAIL basic_strobe: en=%b data=%h, want 1/2c000", obs_en, obs_data);
        end
        idle();
        vectors++;
        if (obs_en !== 1'b0 || obs_data !== 18'h2C000) begin
            miscompares++;
            $display("FAIL basic_hold: en=%b data=%h, want 0/2c000", obs_en, obs_data);
        end
    endtask

    task automatic test_gapped();
        logic [17:0] c;
        c = 18'h1ABCD;
        for (int i = 17; i >= 0; i--) begin
            tick(1'b1, i == 17, c[i], 5'd18);
            vectors++;
            if (obs_en !== 1'b0 || obs_err !== 1'b0) begin
                miscompares++;
                $display("FAIL gapped_quiet: en=%b err=%b, want 0/0", obs_en, obs_err);
            end
            idle();
            vectors++;
            if (obs_en !== 1'b0 || obs_err !== 1'b0) begin
                miscompares++;
                $display("FAIL gapped_quiet_gap: en=%b err=%b, want 0/0", obs_en, obs_err);
            end
        end
        idle();
        vectors++;
        if (obs_en !== 1'b1 || obs_data !== 18'h1ABCD) begin
            miscompares++;
            $display("FAIL gapped_strobe: en=%b data=%h, want 1/1abcd", obs_en, obs_data);
        end
        idle();
    endtask

    task automatic test_back_to_back();
        tick(1'b1, 1'b1, 1'b1, 5'd1);
        tick(1'b1, 1'b1, 1'b0, 5'd1);
        vectors++;
        if (obs_en !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_early: en=%b, want 0", obs_en);
        end
        idle();
        vectors++;
        if (obs_en !== 1'b1 || obs_data !== 18'h20000) begin
            miscompares++;
            $display("FAIL b2b_first: en=%b data=%h, want 1/20000", obs_en, obs_data);
        end
        idle();
        vectors++;
        if (obs_en !== 1'b1 || obs_data !== 18'h00000) begin
            miscompares++;
            $display("FAIL b2b_second: en=%b data=%h, want 1/00000", obs_en, obs_data);
        end
        idle();
        vectors++;
        if (obs_en !== 1'b0 || obs_err !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_after: en=%b err=%b, want 0/0", obs_en, obs_err);
        end
    endtask

    task automatic test_early_sync();
        logic [5:0] c;
        tick(1'b1, 1'b1, 1'b1, 5'd6);
        tick(1'b1, 1'b0, 1'b0, 5'd6);
        tick(1'b1, 1'b0, 1'b1, 5'd6);
        c = 6'b011111;
        for (int i = 5; i >= 0; i--) begin
            tick(1'b1, i == 5, c[i], 5'd6);
            vectors++;
            if (obs_en !== 1'b0 || obs_err !== (i == 4)) begin
                miscompares++;
                $display("FAIL early_sync_err[%0d]: en=%b err=%b, want 0/%b", i, obs_en, obs_err, i == 4);
            end
        end
        idle();
        vectors++;
        if (obs_en !== 1'b0 || obs_err !== 1'b0) begin
            miscompares++;
            $display("FAIL early_sync_gap: en=%b err=%b, want 0/0", obs_en, obs_err);
        end
        idle();
        vectors++;
        if (obs_en !== 1'b1 || obs_data !== 18'h1F000) begin
            miscompares++;
            $display("FAIL early_sync_strobe: en=%b data=%h, want 1/1f000", obs_en, obs_data);
        end
        idle();
    endtask

    task automatic test_illegal();
        logic [NQ_W-1:0] bad [2];
        bad[0] = 5'd0;
        bad[1] = 5'd19;
        for (int k = 0; k < 2; k++) begin
            tick(1'b1, 1'b1, 1'b1, bad[k]);
            idle();
            vectors++;
            if (obs_err !== 1'b1 || obs_en !== 1'b0) begin
                miscompares++;
                $display("FAIL illegal_err nq=%0d: err=%b en=%b, want 1/0", bad[k], obs_err, obs_en);
            end
            idle();
            vectors++;
            if (obs_err !== 1'b0 || obs_en !== 1'b0 || obs_data !== 18'h1F000) begin
                miscompares++;
                $display("FAIL illegal_after nq=%0d: err=%b en=%b data=%h, want 0/0/1f000", bad[k], obs_err, obs_en, obs_data);
            end
        end
        // Unsynced bits must be ignored if the FSM really stayed idle
        for (int k = 0; k < 3; k++) tick(1'b1, 1'b0, 1'b1, 5'd2);
        idle();
        idle();
        vectors++;
        if (obs_err !== 1'b0 || obs_en !== 1'b0 || obs_data !== 18'h1F000) begin
            miscompares++;
            $display("FAIL illegal_idle: err=%b en=%b data=%h, want 0/0/1f000", obs_err, obs_en, obs_data);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] c;
        tick(1'b1, 1'b1, 1'b1, 5'd8);
        tick(1'b1, 1'b0, 1'b0, 5'd8);
        reset = 1'b1;
        idle();
        reset = 1'b0;
        idle();
        vectors++;
        if (obs_en !== 1'b0 || obs_err !== 1'b0 || obs_data !== '0) begin
            miscompares++;
            $display("FAIL reset_mid: en=%b err=%b data=%h, want 0/0/00000", obs_en, obs_err, obs_data);
        end
        c = 8'hFF;
        for (int i = 7; i >= 0; i--) begin
            tick(1'b1, i == 7, c[i], 5'd8);
            vectors++;
            if (obs_en !== 1'b0 || obs_err !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_mid_quiet: en=%b err=%b, want 0/0", obs_en, obs_err);
            end
        end
        idle();
        idle();
        vectors++;
        if (obs_en !== 1'b1 || obs_data !== 18'h3FC00) begin
            miscompares++;
            $display("FAIL reset_mid_fresh: en=%b data=%h, want 1/3fc00", obs_en, obs_data);
        end
        idle();
    endtask

    task automatic test_random();
        stim_t         q[$];
        logic [DW-1:0] exp_map[int];
        logic [DW-1:0] hold;
        logic [31:0]   code;
        int unsigned   nq;
        int unsigned   pre;
        stim_t         s;
        for (int k = 0; k < 60; k++) begin
            pre = $urandom_range(0, 2);
            for (int g = 0; g < int'(pre); g++) begin
                s.en   = 1'($urandom);
                s.sync = 1'b0;
                s.b    = 1'($urandom);
                s.nq   = NQ_W'($urandom);
                q.push_back(s);
            end
            nq   = $urandom_range(1, DW);
            code = $urandom & ((32'd1 << nq) - 32'd1);
            for (int i = int'(nq) - 1; i >= 0; i--) begin
                s.en   = 1'b1;
                s.sync = (i == int'(nq) - 1);
                s.b    = code[i];
                s.nq   = s.sync ? NQ_W'(nq) : NQ_W'($urandom);
                q.push_back(s);
                if (i > 0 && $urandom_range(0, 3) == 0) begin
                    s.en   = 1'b0;
                    s.sync = 1'($urandom);
                    s.b    = 1'($urandom);
                    s.nq   = NQ_W'($urandom);
                    q.push_back(s);
                end
            end
            exp_map[q.size() + 1] = ref_sample(code, nq);
        end
        s = '0;
        for (int k = 0; k < 3; k++) q.push_back(s);
        hold = 18'h3FC00;
        for (int t = 0; t < q.size(); t++) begin
            s = q[t];
            tick(s.en, s.sync, s.b, s.nq);
            vectors++;
            if (exp_map.exists(t)) begin
                if (obs_en !== 1'b1 || obs_err !== 1'b0 || obs_data !== exp_map[t]) begin
                    miscompares++;
                    $display("FAIL random_strobe t=%0d: en=%b err=%b data=%h, want 1/0/%h", t, obs_en, obs_err, obs_data, exp_map[t]);
                end
                hold = exp_map[t];
            end else if (obs_en !== 1'b0 || obs_err !== 1'b0 || obs_data !== hold) begin
                miscompares++;
                $display("FAIL random_quiet t=%0d: en=%b err=%b data=%h, want 0/0/%h", t, obs_en, obs_err, obs_data, hold);
            end
        end
    endtask

    initial begin
        bus.sin_en   = 1'b0;
        bus.sin_sync = 1'b0;
        bus.sin      = 1'b0;
        bus.Nquant   = '0;
        test_reset();
        test_basic();
        test_gapped();
        test_back_to_back();
        test_early_sync();
        test_illegal();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, vectors=%0d", vectors);
        $fatal(1, "time limit");
    end

endmodule
